// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing the frame-buffer write port between three burst producers.
// Optional macro FBW_VBLANK_GATE_EN: accept writes only while active_pixels is low.
module fb_write_arbiter #(
    parameter int NREQ     = 3,
    parameter int FB_WORDS = 19200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_last,
    input  logic [15*NREQ-1:0]   req_addr,
    input  logic [24*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 active_pixels,
    output logic [14:0]          the_vga_draw_frame_write_mem_address,
    output logic [23:0]          the_vga_draw_frame_write_mem_data,
    output logic                 the_vga_draw_frame_write_a_pixel,
    output logic [1:0]           grant_id,
    output logic [7:0]           drop_count,
    output logic                 dbg_state,
    output logic [1:0]           dbg_rr_ptr
);

    // Handshake: a write from requester i transfers on a rising edge where
    // req_valid[i] & req_ready[i]; req_ready never depends on anything but
    // req_valid, the FSM state, reset and the blanking gate.

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [15:0] FB_LIMIT = 16'(FB_WORDS);

    state_t      state, next_state;
    logic [1:0]  owner, next_owner;
    logic [1:0]  rr_ptr, next_rr;
    logic [1:0]  sel, cand;
    logic        sel_ok;
    logic        gated;
    logic        accept;
    logic        in_range;
    logic [14:0] sel_addr;
    logic [23:0] sel_data;

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

`ifdef FBW_VBLANK_GATE_EN
    assign gated = active_pixels;
`else
    logic unused_active_pixels;
    assign unused_active_pixels = active_pixels;
    assign gated = 1'b0;
`endif

    always_comb begin
        sel        = 2'd0;
        sel_ok     = 1'b0;
        cand       = 2'd0;
        next_state = state;
        next_owner = owner;
        next_rr    = rr_ptr;
        req_ready  = '0;
        grant_id   = 2'd3;
        sel_addr   = '0;
        sel_data   = '0;

        // Scan from the far end so the requester closest to rr_ptr wins last.
        if (state == IDLE) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                cand = wrap3({1'b0, rr_ptr} + 3'(k));
                if (req_valid[cand]) begin
                    sel    = cand;
                    sel_ok = 1'b1;
                end
            end
        end else begin
            sel    = owner;
            sel_ok = req_valid[owner];
        end

        accept = sel_ok && rst && !gated;

        for (int i = 0; i < NREQ; i++) begin
            if (sel == i[1:0]) begin
                sel_addr = req_addr[i*15 +: 15];
                sel_data = req_data[i*24 +: 24];
            end
        end
        in_range = ({1'b0, sel_addr} < FB_LIMIT);

        if (accept) begin
            req_ready[sel] = 1'b1;
        end

        if (!rst) begin
            grant_id = 2'd3;
        end else if (state == LOCKED) begin
            grant_id = owner;
        end else if (accept) begin
            grant_id = sel;
        end

        if (accept) begin
            if (req_last[sel]) begin
                next_state = IDLE;
                next_rr    = wrap3({1'b0, sel} + 3'd1);
            end else begin
                next_state = LOCKED;
                next_owner = sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            owner  <= 2'd0;
            rr_ptr <= 2'd0;
        end else begin
            state  <= next_state;
            owner  <= next_owner;
            rr_ptr <= next_rr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            the_vga_draw_frame_write_mem_address <= '0;
            the_vga_draw_frame_write_mem_data    <= '0;
            the_vga_draw_frame_write_a_pixel     <= 1'b0;
            drop_count                           <= '0;
        end else begin
            the_vga_draw_frame_write_a_pixel <= accept && in_range;
            if (accept && in_range) begin
                the_vga_draw_frame_write_mem_address <= sel_addr;
                the_vga_draw_frame_write_mem_data    <= sel_data;
            end
            if (accept && !in_range && drop_count != 8'hff) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    assign dbg_state  = state;
    assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: round robin, burst lock, drops, saturation, reset and blanking gate.
// Build with +define+FBW_VBLANK_GATE_EN to exercise the gated variant.
module tb_fb_write_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid, req_last, req_ready;
    logic [44:0] req_addr;
    logic [71:0] req_data;
    logic        active_pixels;
    logic [14:0] mem_address;
    logic [23:0] mem_data;
    logic        a_pixel;
    logic [1:0]  grant_id;
    logic [7:0]  drop_count;
    logic        dbg_state;
    logic [1:0]  dbg_rr_ptr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic        v[3];
    logic        l[3];
    logic [14:0] a[3];
    logic [2:0]  last_ready;
    logic [1:0]  last_gid;
    int          last_cyc;

    logic [38:0] exp_q[$];
    logic [38:0] got_q[$];
    int          strobe_cyc_q[$];

    fb_write_arbiter dut (
        .clk                                  (clk),
        .rst                                  (rst),
        .req_valid                            (req_valid),
        .req_last                             (req_last),
        .req_addr                             (req_addr),
        .req_data                             (req_data),
        .req_ready                            (req_ready),
        .active_pixels                        (active_pixels),
        .the_vga_draw_frame_write_mem_address (mem_address),
        .the_vga_draw_frame_write_mem_data    (mem_data),
        .the_vga_draw_frame_write_a_pixel     (a_pixel),
        .grant_id                             (grant_id),
        .drop_count                           (drop_count),
        .dbg_state                            (dbg_state),
        .dbg_rr_ptr                           (dbg_rr_ptr)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && a_pixel) begin
            got_q.push_back({mem_address, mem_data});
            strobe_cyc_q.push_back(cyc);
        end
    end

    // driver tasks
    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            req_valid[i]          = v[i];
            req_last[i]           = l[i];
            req_addr[i*15 +: 15]  = a[i];
            req_data[i*24 +: 24]  = {9'(i), a[i]};
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b0;
            l[i] = 1'b0;
            a[i] = '0;
        end
        drive();
    endtask

    task automatic step();
        @(negedge clk);
        last_ready = req_ready;
        last_gid   = grant_id;
        last_cyc   = cyc;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [38:0] exp_word(input int id, input int addr);
        return {15'(addr), 9'(id), 15'(addr)};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        active_pixels = 1'b0;
        idle_all();
        repeat (3) @(posedge clk);
        #2;
        total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
        total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL reset_grant got=%0d exp=3", grant_id); end
        total++; if (a_pixel !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b exp=0", a_pixel); end
        total++; if (mem_address !== 15'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", mem_address); end
        total++; if (mem_data !== 24'd0) begin bad++; $display("FAIL reset_data got=%0h exp=0", mem_data); end
        total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
        total++; if (dbg_rr_ptr !== 2'd0) begin bad++; $display("FAIL reset_rr got=%0d exp=0", dbg_rr_ptr); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
    endtask

    task automatic test_round_robin();
        int cnt[3];
        int base[3];
        logic [1:0] gids[$];
        logic [1:0] exp_gid[6];
        int first_acc;
        base = '{0, 100, 200};
        exp_gid = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
        first_acc = -1;
        got_q.delete(); strobe_cyc_q.delete(); exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0;
            for (int j = 0; j < 2; j++) exp_q.push_back(exp_word(i, base[i] + j));
        end
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < 3; i++) begin
                v[i] = (cnt[i] < 2);
                l[i] = (cnt[i] == 1);
                a[i] = 15'(base[i] + cnt[i]);
            end
            drive();
            step();
            for (int i = 0; i < 3; i++) begin
                if (last_ready[i]) begin
                    gids.push_back(last_gid);
                    if (first_acc < 0) first_acc = last_cyc;
                    cnt[i]++;
                end
            end
        end
        idle_all();
        step(); step();
        total++;
        if (got_q.size() != 6 || gids.size() != 6) begin
            bad++; $display("FAIL rr_count strobes=%0d grants=%0d exp=6", got_q.size(), gids.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL rr_write[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
                total++; if (gids[k] !== exp_gid[k]) begin bad++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", k, gids[k], exp_gid[k]); end
            end
            total++; if (strobe_cyc_q[0] != first_acc + 1) begin bad++; $display("FAIL rr_latency got=%0d exp=%0d", strobe_cyc_q[0], first_acc + 1); end
            for (int k = 1; k < 6; k++) begin
                total++; if (strobe_cyc_q[k] != strobe_cyc_q[k-1] + 1) begin bad++; $display("FAIL rr_b2b[%0d] got=%0d exp=%0d", k, strobe_cyc_q[k], strobe_cyc_q[k-1] + 1); end
            end
        end
    endtask

    task automatic test_hold_grant();
        int cnt0, cnt1, pause;
        cnt0 = 0; cnt1 = 0; pause = 0;
        got_q.delete(); exp_q.delete();
        for (int j = 0; j < 4; j++) exp_q.push_back(exp_word(0, 10 + j));
        exp_q.push_back(exp_word(1, 500));
        for (int c = 0; c < 14; c++) begin
            v[0] = (cnt0 < 4) && !(cnt0 == 2 && pause < 3);
            l[0] = (cnt0 == 3);
            a[0] = 15'(10 + cnt0);
            v[1] = (cnt1 < 1);
            l[1] = 1'b1;
            a[1] = 15'd500;
            v[2] = 1'b0;
            drive();
            step();
            if (cnt0 == 2 && pause < 3) begin
                total++; if (last_gid !== 2'd0) begin bad++; $display("FAIL hold_grant got=%0d exp=0", last_gid); end
                total++; if (last_ready !== 3'b000) begin bad++; $display("FAIL hold_ready got=%b exp=000", last_ready); end
                pause++;
            end
            if (last_ready[1] && cnt0 < 4) begin
                total++; bad++; $display("FAIL hold_steal got=r1_accept exp=none cnt0=%0d", cnt0);
            end
            if (last_ready[0]) cnt0++;
            if (last_ready[1]) cnt1++;
        end
        idle_all();
        step(); step();
        total++;
        if (got_q.size() != 5) begin
            bad++; $display("FAIL hold_count got=%0d exp=5", got_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL hold_write[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
            end
        end
    endtask

    task automatic test_drop();
        int cnt2;
        cnt2 = 0;
        got_q.delete();
        for (int c = 0; c < 5; c++) begin
            v[2] = (cnt2 < 2);
            l[2] = (cnt2 == 1);
            a[2] = (cnt2 == 0) ? 15'd19200 : 15'd19199;
            drive();
            step();
            if (last_ready[2]) cnt2++;
        end
        idle_all();
        step();
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL drop_strobes got=%0d exp=1", got_q.size()); end
        else begin
            total++; if (got_q[0] !== exp_word(2, 19199)) begin bad++; $display("FAIL drop_write got=%h exp=%h", got_q[0], exp_word(2, 19199)); end
        end
        total++; if (drop_count !== 8'd1) begin bad++; $display("FAIL drop_count got=%0d exp=1", drop_count); end
        total++; if (dbg_state !== 1'b0) begin bad++; $display("FAIL drop_release got=%b exp=0", dbg_state); end
        total++; if (dbg_rr_ptr !== 2'd0) begin bad++; $display("FAIL drop_rr got=%0d exp=0", dbg_rr_ptr); end
        v[0] = 1'b1; l[0] = 1'b1; a[0] = 15'd7;
        drive();
        step();
        total++; if (last_ready !== 3'b001) begin bad++; $display("FAIL drop_next_ready got=%b exp=001", last_ready); end
        idle_all();
        step();
    endtask

    task automatic test_saturate();
        got_q.delete();
        for (int k = 0; k < 300; k++) begin
            v[0] = 1'b1; l[0] = 1'b1; a[0] = 15'(19200 + (k % 1000));
            drive();
            step();
            if (k == 99) begin
                total++; if (drop_count !== 8'd101) begin bad++; $display("FAIL sat_mid got=%0d exp=101", drop_count); end
            end
            if (k == 253) begin
                total++; if (drop_count !== 8'd255) begin bad++; $display("FAIL sat_edge got=%0d exp=255", drop_count); end
            end
        end
        idle_all();
        step();
        total++; if (drop_count !== 8'd255) begin bad++; $display("FAIL sat_final got=%0d exp=255", drop_count); end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL sat_strobes got=%0d exp=0", got_q.size()); end
    endtask

    task automatic test_reset_mid();
        int cnt0, cnt1;
        int first_gid;
        cnt1 = 0;
        for (int c = 0; c < 2; c++) begin
            v[1] = 1'b1; l[1] = 1'b0; a[1] = 15'(300 + cnt1);
            drive();
            step();
            if (last_ready[1]) cnt1++;
        end
        rst = 1'b0;
        #2;
        total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL rstmid_ready got=%b exp=000", req_ready); end
        total++; if (grant_id !== 2'd3) begin bad++; $display("FAIL rstmid_grant got=%0d exp=3", grant_id); end
        total++; if (a_pixel !== 1'b0) begin bad++; $display("FAIL rstmid_strobe got=%b exp=0", a_pixel); end
        total++; if (mem_address !== 15'd0) begin bad++; $display("FAIL rstmid_addr got=%0d exp=0", mem_address); end
        total++; if (mem_data !== 24'd0) begin bad++; $display("FAIL rstmid_data got=%0h exp=0", mem_data); end
        total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL rstmid_drop got=%0d exp=0", drop_count); end
        total++; if (dbg_state !== 1'b0) begin bad++; $display("FAIL rstmid_state got=%b exp=0", dbg_state); end
        total++; if (dbg_rr_ptr !== 2'd0) begin bad++; $display("FAIL rstmid_rr got=%0d exp=0", dbg_rr_ptr); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        got_q.delete(); exp_q.delete();
        exp_q.push_back(exp_word(0, 5));
        exp_q.push_back(exp_word(1, 300));
        exp_q.push_back(exp_word(1, 301));
        rst = 1'b1;
        cnt0 = 0; cnt1 = 0; first_gid = -1;
        for (int c = 0; c < 6; c++) begin
            v[0] = (cnt0 < 1); l[0] = 1'b1; a[0] = 15'd5;
            v[1] = (cnt1 < 2); l[1] = (cnt1 == 1); a[1] = 15'(300 + cnt1);
            drive();
            step();
            if (last_ready != 3'b000 && first_gid < 0) first_gid = int'(last_gid);
            if (last_ready[0]) cnt0++;
            if (last_ready[1]) cnt1++;
        end
        idle_all();
        step(); step();
        total++; if (first_gid != 0) begin bad++; $display("FAIL rstmid_first got=%0d exp=0", first_gid); end
        total++;
        if (got_q.size() != 3) begin
            bad++; $display("FAIL rstmid_count got=%0d exp=3", got_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL rstmid_write[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
            end
        end
    endtask

`ifdef FBW_VBLANK_GATE_EN
    task automatic test_vblank_gate();
        int cnt0;
        logic started;
        cnt0 = 0; started = 1'b0;
        got_q.delete(); exp_q.delete();
        for (int j = 0; j < 20; j++) exp_q.push_back(exp_word(0, 1000 + j));
        for (int c = 0; c < 90; c++) begin
            active_pixels = ((c % 15) < 10);
            v[0] = (cnt0 < 20); l[0] = (cnt0 == 19); a[0] = 15'(1000 + cnt0);
            drive();
            step();
            if (active_pixels) begin
                total++; if (last_ready !== 3'b000) begin bad++; $display("FAIL gate_ready got=%b exp=000 cycle=%0d", last_ready, c); end
            end
            if (started && cnt0 < 20) begin
                total++; if (last_gid !== 2'd0) begin bad++; $display("FAIL gate_grant got=%0d exp=0 cycle=%0d", last_gid, c); end
            end
            if (last_ready[0]) begin
                started = 1'b1;
                cnt0++;
            end
        end
        active_pixels = 1'b0;
        idle_all();
        step(); step();
        total++;
        if (got_q.size() != 20) begin
            bad++; $display("FAIL gate_count got=%0d exp=20", got_q.size());
        end else begin
            for (int k = 0; k < 20; k++) begin
                total++; if (got_q[k] !== exp_q[k]) begin bad++; $display("FAIL gate_write[%0d] got=%h exp=%h", k, got_q[k], exp_q[k]); end
            end
        end
    endtask
`else
    task automatic test_ungated();
        got_q.delete();
        active_pixels = 1'b1;
        v[0] = 1'b1; l[0] = 1'b1; a[0] = 15'd42;
        drive();
        step();
        total++; if (last_ready !== 3'b001) begin bad++; $display("FAIL ungated_ready got=%b exp=001", last_ready); end
        idle_all();
        step();
        active_pixels = 1'b0;
        total++;
        if (got_q.size() != 1) begin
            bad++; $display("FAIL ungated_count got=%0d exp=1", got_q.size());
        end else begin
            total++; if (got_q[0] !== exp_word(0, 42)) begin bad++; $display("FAIL ungated_write got=%h exp=%h", got_q[0], exp_word(0, 42)); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_hold_grant();
        test_drop();
        test_saturate();
        test_reset_mid();
`ifdef FBW_VBLANK_GATE_EN
        test_vblank_gate();
`else
        test_ungated();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
